// File: rtl/mc_ctrl_pkg.sv
// Shared MIPS-subset definitions: opcode/funct fields, controller states and
// the datapath select codes also used by the IFU and ALU.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXE_R   = 4'd2,
    S_EXE_I   = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_R    = 4'd7,
    S_WB_I    = 4'd8,
    S_WB_MEM  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] RD_RT   = 2'b00;
  localparam logic [1:0] RD_RD   = 2'b01;
  localparam logic [1:0] RD_RA   = 2'b10;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_MEM  = 2'b01;
  localparam logic [1:0] WD_PC4  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_LUI = 2'b11;

  typedef struct packed {
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       ext_op;
    logic       mem_wr;
    logic       mem_rd;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    ir_wr: 1'b0, pc_wr: 1'b0, npc_sel: 2'b00, reg_wr: 1'b0, reg_dst: 2'b00,
    wd_sel: 2'b00, alu_src: 1'b0, alu_op: 2'b00, ext_op: 1'b0,
    mem_wr: 1'b0, mem_rd: 1'b0
  };

endpackage

// File: rtl/mc_ctrl_out.sv
// Control-word decoder: maps the current state (plus IR fields where a state
// serves several instructions) onto every datapath enable and select.
module mc_ctrl_out
  import mips_defs::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output ctrl_t      ctrl
);

  // Moore decode; only the BRANCH pc_wr looks at a live input.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.ir_wr   = 1'b1;
        ctrl.pc_wr   = 1'b1;
        ctrl.npc_sel = NPC_PC4;
      end
      S_EXE_R: begin
        ctrl.alu_src = 1'b0;
        ctrl.alu_op  = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
      end
      S_EXE_I: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = (opcode == OP_LUI) ? ALU_LUI : ALU_OR;
        ctrl.ext_op  = 1'b0;
      end
      S_MEM_ADR: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_ADD;
        ctrl.ext_op  = 1'b1;
      end
      S_MEM_RD: ctrl.mem_rd = 1'b1;
      S_MEM_WR: ctrl.mem_wr = 1'b1;
      S_WB_R: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.reg_dst = RD_RD;
        ctrl.wd_sel  = WD_ALU;
      end
      S_WB_I: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.reg_dst = RD_RT;
        ctrl.wd_sel  = WD_ALU;
      end
      S_WB_MEM: begin
        ctrl.reg_wr  = 1'b1;
        ctrl.reg_dst = RD_RT;
        ctrl.wd_sel  = WD_MEM;
      end
      S_BRANCH: begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.alu_src = 1'b0;
        ctrl.ext_op  = 1'b1;
        ctrl.npc_sel = NPC_BR;
        ctrl.pc_wr   = zero;
      end
      S_JUMP: begin
        ctrl.pc_wr = 1'b1;
        case (opcode)
          OP_RTYPE: ctrl.npc_sel = NPC_JR;
          OP_JAL: begin
            ctrl.npc_sel = NPC_J;
            ctrl.reg_wr  = 1'b1;
            ctrl.reg_dst = RD_RA;
            ctrl.wd_sel  = WD_PC4;
          end
          default:  ctrl.npc_sel = NPC_J;
        endcase
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: state register, instruction dispatch,
// data-memory handshake, sticky illegal flag and retired-instruction counter.
module mc_ctrl
  import mips_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       npc_sel,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             ext_op,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_r;
  state_e           next_state_s;
  logic             dec_illegal_s;
  logic             retire_s;
  logic             illegal_r;
  logic [CNT_W-1:0] cnt_r;
  ctrl_t            ctrl_s;

  // Next-state selection and instruction classification.
  always_comb begin
    next_state_s  = state_r;
    dec_illegal_s = 1'b0;
    case (state_r)
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADDU, FN_SUBU: next_state_s = S_EXE_R;
              FN_JR:            next_state_s = S_JUMP;
              default: begin
                next_state_s  = S_FETCH;
                dec_illegal_s = 1'b1;
              end
            endcase
          end
          OP_ORI, OP_LUI: next_state_s = S_EXE_I;
          OP_LW, OP_SW:   next_state_s = S_MEM_ADR;
          OP_BEQ:         next_state_s = S_BRANCH;
          OP_J, OP_JAL:   next_state_s = S_JUMP;
          default: begin
            next_state_s  = S_FETCH;
            dec_illegal_s = 1'b1;
          end
        endcase
      end
      S_EXE_R:   next_state_s = S_WB_R;
      S_EXE_I:   next_state_s = S_WB_I;
      S_MEM_ADR: next_state_s = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  next_state_s = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:  next_state_s = mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: next_state_s = S_FETCH;
      default:   next_state_s = S_FETCH;
    endcase
  end

  // The only non-retiring way back to FETCH (besides reset) is the illegal path.
  assign retire_s = (next_state_s == S_FETCH) && (state_r != S_FETCH) && !dec_illegal_s;

  // State, sticky illegal flag and wrap-around retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_FETCH;
      illegal_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (dec_illegal_s) begin
        illegal_r <= 1'b1;
      end
      if (retire_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  mc_ctrl_out u_out (
    .state  (state_r),
    .opcode (opcode),
    .funct  (funct),
    .zero   (zero),
    .ctrl   (ctrl_s)
  );

  assign ir_wr     = ctrl_s.ir_wr;
  assign pc_wr     = ctrl_s.pc_wr;
  assign npc_sel   = ctrl_s.npc_sel;
  assign reg_wr    = ctrl_s.reg_wr;
  assign reg_dst   = ctrl_s.reg_dst;
  assign wd_sel    = ctrl_s.wd_sel;
  assign alu_src   = ctrl_s.alu_src;
  assign alu_op    = ctrl_s.alu_op;
  assign ext_op    = ctrl_s.ext_op;
  assign mem_wr    = ctrl_s.mem_wr;
  assign mem_rd    = ctrl_s.mem_rd;
  assign illegal   = illegal_r;
  assign instr_cnt = cnt_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomised bench for mc_ctrl: each instruction is expanded into its expected
// per-cycle control words, which a compare process checks every cycle.
module tb_mc_ctrl;

  localparam int CW = 4;

  // Control word layout: ir,pc,npc[2],rw,rdst[2],wd[2],asrc,aop[2],ext,mw,mr
  localparam logic [14:0] W_FETCH = 15'b1_1_00_0_00_00_0_00_0_0_0;
  localparam logic [14:0] W_IDLE  = 15'b0_0_00_0_00_00_0_00_0_0_0;
  localparam logic [14:0] W_ADDU  = 15'b0_0_00_0_00_00_0_00_0_0_0;
  localparam logic [14:0] W_SUBU  = 15'b0_0_00_0_00_00_0_01_0_0_0;
  localparam logic [14:0] W_ORI   = 15'b0_0_00_0_00_00_1_10_0_0_0;
  localparam logic [14:0] W_LUI   = 15'b0_0_00_0_00_00_1_11_0_0_0;
  localparam logic [14:0] W_MADR  = 15'b0_0_00_0_00_00_1_00_1_0_0;
  localparam logic [14:0] W_MRD   = 15'b0_0_00_0_00_00_0_00_0_0_1;
  localparam logic [14:0] W_MWR   = 15'b0_0_00_0_00_00_0_00_0_1_0;
  localparam logic [14:0] W_WBR   = 15'b0_0_00_1_01_00_0_00_0_0_0;
  localparam logic [14:0] W_WBI   = 15'b0_0_00_1_00_00_0_00_0_0_0;
  localparam logic [14:0] W_WBM   = 15'b0_0_00_1_00_01_0_00_0_0_0;
  localparam logic [14:0] W_BEQ0  = 15'b0_0_01_0_00_00_0_01_1_0_0;
  localparam logic [14:0] W_BEQ1  = 15'b0_1_01_0_00_00_0_01_1_0_0;
  localparam logic [14:0] W_J     = 15'b0_1_10_0_00_00_0_00_0_0_0;
  localparam logic [14:0] W_JAL   = 15'b0_1_10_1_10_10_0_00_0_0_0;
  localparam logic [14:0] W_JR    = 15'b0_1_11_0_00_00_0_00_0_0_0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = 6'b0;
  logic [5:0]    funct = 6'b0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          ir_wr, pc_wr, reg_wr, alu_src, ext_op, mem_wr, mem_rd, illegal;
  logic [1:0]    npc_sel, reg_dst, wd_sel, alu_op;
  logic [CW-1:0] instr_cnt;
  logic [14:0]   dut_vec;

  int          tests = 0;
  int          fails = 0;
  logic        chk_en = 1'b0;
  logic [14:0] exp_cw = 15'b0;
  logic        exp_ill = 1'b0;
  int          exp_cnt = 0;
  int          cnt_m = 0;
  logic        ill_m = 1'b0;
  int          last_len = 0;
  logic [14:0] exp_q[$];
  int          rdy_q[$];
  logic [14:0] obs_q[$];

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ir_wr(ir_wr), .pc_wr(pc_wr), .npc_sel(npc_sel),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src),
    .alu_op(alu_op), .ext_op(ext_op), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  assign dut_vec = {ir_wr, pc_wr, npc_sel, reg_wr, reg_dst, wd_sel, alu_src, alu_op,
                    ext_op, mem_wr, mem_rd};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctrl_word", 32'(dut_vec), 32'(exp_cw));
      chk("illegal", 32'(illegal), 32'(exp_ill));
      chk("instr_cnt", 32'(instr_cnt), 32'(exp_cnt));
    end
  end

  // rdy: 0 = hold mem_ready low, 1 = raise it, 2 = don't care (random)
  task automatic push(input logic [14:0] w, input int rdy);
    exp_q.push_back(w);
    rdy_q.push_back(rdy);
  endtask

  task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input int k, output logic bad);
    exp_q.delete();
    rdy_q.delete();
    bad = 1'b0;
    push(W_FETCH, 2);
    push(W_IDLE, 2);
    case (op)
      6'b000000: begin
        if (fn == 6'b100001) begin push(W_ADDU, 2); push(W_WBR, 2); end
        else if (fn == 6'b100011) begin push(W_SUBU, 2); push(W_WBR, 2); end
        else if (fn == 6'b001000) push(W_JR, 2);
        else bad = 1'b1;
      end
      6'b001101: begin push(W_ORI, 2); push(W_WBI, 2); end
      6'b001111: begin push(W_LUI, 2); push(W_WBI, 2); end
      6'b100011: begin
        push(W_MADR, 2);
        for (int j = 0; j < k; j++) push(W_MRD, 0);
        push(W_MRD, 1);
        push(W_WBM, 2);
      end
      6'b101011: begin
        push(W_MADR, 2);
        for (int j = 0; j < k; j++) push(W_MWR, 0);
        push(W_MWR, 1);
      end
      6'b000100: push(z ? W_BEQ1 : W_BEQ0, 2);
      6'b000010: push(W_J, 2);
      6'b000011: push(W_JAL, 2);
      default:   bad = 1'b1;
    endcase
  endtask

  // Called #1 after a posedge with the DUT in FETCH; returns likewise.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int k, input int rst_at);
    logic bad;
    int   n;
    plan(op, fn, z, k, bad);
    n = exp_q.size();
    last_len = n;
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      opcode = op;
      funct  = fn;
      zero   = z;
      if (rdy_q[i] == 2) mem_ready = ($urandom_range(0, 1) == 1);
      else mem_ready = (rdy_q[i] == 1);
      reset   = (rst_at == i + 1);
      exp_cw  = exp_q[i];
      exp_ill = ill_m;
      exp_cnt = cnt_m;
      chk_en  = 1'b1;
      @(negedge clk);
      obs_q.push_back(dut_vec);
      @(posedge clk);
      #1;
      if (rst_at == i + 1) break;
    end
    reset = 1'b0;
    if (rst_at > 0) begin
      cnt_m = 0;
      ill_m = 1'b0;
    end else if (bad) begin
      ill_m = 1'b1;
    end else begin
      cnt_m = (cnt_m + 1) % (1 << CW);
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt_m = 0;
    ill_m = 1'b0;
  endtask

  task automatic pick(input logic legal_only, output logic [5:0] op, output logic [5:0] fn);
    int r;
    r  = legal_only ? $urandom_range(0, 9) : $urandom_range(0, 12);
    fn = 6'($urandom);
    case (r)
      0:  begin op = 6'b000000; fn = 6'b100001; end
      1:  begin op = 6'b000000; fn = 6'b100011; end
      2:  begin op = 6'b000000; fn = 6'b001000; end
      3:  op = 6'b001101;
      4:  op = 6'b001111;
      5:  op = 6'b100011;
      6:  op = 6'b101011;
      7:  op = 6'b000100;
      8:  op = 6'b000010;
      9:  op = 6'b000011;
      10: op = 6'b000000;
      default: op = 6'($urandom);
    endcase
  endtask

  initial begin
    logic [5:0] op, fn;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_word", 32'(dut_vec), 32'(W_FETCH));
    chk("reset_cnt", 32'(instr_cnt), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);

    run(6'b000000, 6'b100001, 1'b0, 0, 0);
    chk("addu_len", 32'(last_len), 32'd4);
    chk("addu_wb", 32'(obs_q[3]), 32'(15'b0_0_00_1_01_00_0_00_0_0_0));
    chk("addu_cnt", 32'(instr_cnt), 32'd1);

    run(6'b100011, 6'b000000, 1'b0, 3, 0);
    chk("lw_len", 32'(last_len), 32'd8);
    chk("lw_rd_last", 32'(obs_q[6]), 32'(15'b0_0_00_0_00_00_0_00_0_0_1));
    chk("lw_wb", 32'(obs_q[7]), 32'(15'b0_0_00_1_00_01_0_00_0_0_0));
    chk("lw_cnt", 32'(instr_cnt), 32'd2);

    run(6'b101011, 6'b000000, 1'b0, 5, 5);
    chk("sw_rst_memwr", 32'(mem_wr), 32'd0);
    chk("sw_rst_irwr", 32'(ir_wr), 32'd1);
    chk("sw_rst_cnt", 32'(instr_cnt), 32'd0);

    run(6'b000100, 6'b000000, 1'b1, 0, 0);
    chk("beq1_len", 32'(last_len), 32'd3);
    chk("beq1_word", 32'(obs_q[2]), 32'(15'b0_1_01_0_00_00_0_01_1_0_0));
    run(6'b000100, 6'b000000, 1'b0, 0, 0);
    chk("beq0_pcwr", 32'(obs_q[2][13]), 32'd0);
    chk("beq_cnt", 32'(instr_cnt), 32'd2);

    run(6'b000011, 6'b000000, 1'b0, 0, 0);
    chk("jal_word", 32'(obs_q[2]), 32'(15'b0_1_10_1_10_10_0_00_0_0_0));
    run(6'b000000, 6'b001000, 1'b0, 0, 0);
    chk("jr_npc", 32'(obs_q[2][12:11]), 32'd3);

    run(6'b111111, 6'b000000, 1'b0, 0, 0);
    chk("ill_len", 32'(last_len), 32'd2);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_cnt", 32'(instr_cnt), 32'd4);
    run(6'b001101, 6'b000000, 1'b0, 0, 0);
    chk("ill_sticky", 32'(illegal), 32'd1);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      pick(1'b1, op, fn);
      run(op, fn, 1'($urandom), $urandom_range(0, 3), 0);
      if (i == 14) chk("wrap_15", 32'(instr_cnt), 32'd15);
    end
    chk("wrap_0", 32'(instr_cnt), 32'd0);

    for (int i = 0; i < 200; i++) begin
      pick(1'b0, op, fn);
      run(op, fn, 1'($urandom), $urandom_range(0, 4), 0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
